// File: rtl/i2s2_adc_rx.sv
// I2S line-in receiver for the PmodI2S2 ADC (CS5343 in slave mode).
// Divides the 98.304 MHz audio clock into MCLK/SCLK/LRCK for a 48 kHz,
// 64-SCLK-per-frame stream and deserializes SDOUT into left/right words.
module i2s2_adc_rx #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              adc_sdout,
  output logic              mclk_o,
  output logic              sclk_o,
  output logic              lrck_o,
  output logic [DATA_W-1:0] left_o,
  output logic [DATA_W-1:0] right_o,
  output logic              valid_o
);
  // Slot index of the LSB within a half frame (slot 0 is the I2S delay bit).
  localparam logic [4:0] LAST_B = 5'(DATA_W);

  logic [10:0]       r_cnt;
  logic              r_sd;
  logic [DATA_W-2:0] r_shift;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_left;
  logic [DATA_W-1:0] r_right;
  logic              r_left_ok;
  logic              r_valid;

  logic              w_inst;
  logic              w_ch;
  logic [4:0]        w_b;
  logic [DATA_W-1:0] w_word;

  // Sample instant is the first clk with SCLK high, 16 clks after the ADC
  // launched the bit on the SCLK falling edge.
  assign w_inst = (r_cnt[4:0] == 5'd16);
  assign w_ch   = r_cnt[10];
  assign w_b    = r_cnt[9:5];
  // Word as it stands once the current bit is shifted in.
  assign w_word = {r_shift, r_sd};

  // Serial clocks come straight from counter flops, so no decode glitches.
  assign mclk_o  = r_cnt[1];
  assign sclk_o  = r_cnt[4];
  assign lrck_o  = r_cnt[10];
  assign left_o  = r_left;
  assign right_o = r_right;
  assign valid_o = r_valid;

  // Free-running frame counter; en low parks it at the start of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_cnt <= '0;
    else if (!en) r_cnt <= '0;
    else          r_cnt <= r_cnt + 11'd1;
  end

  // Single retiming flop on the asynchronous ADC data line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sd <= 1'b0;
    else        r_sd <= adc_sdout;
  end

  // Deserializer: shift data slots, hold left word, publish the pair at the
  // end of the right word. r_left_ok gates out frames whose left slot was lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_hold    <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_left_ok <= 1'b0;
      r_valid   <= 1'b0;
    end else if (!en) begin
      r_shift   <= '0;
      r_left_ok <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_inst) begin
        if (w_b == 5'd0)         r_shift <= '0;
        else if (w_b <= LAST_B)  r_shift <= w_word[DATA_W-2:0];
        if (w_b == LAST_B) begin
          if (!w_ch) begin
            r_hold    <= w_word;
            r_left_ok <= 1'b1;
          end else begin
            r_left_ok <= 1'b0;
            if (r_left_ok) begin
              r_left  <= r_hold;
              r_right <= w_word;
              r_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s2_adc_rx.sv
// Bench for i2s2_adc_rx: a DATA_W=24 and a DATA_W=16 instance share clock,
// reset and enable; a frame-level I2S source model drives each ADC line.
module tb_i2s2_adc_rx;
  localparam int VPOS_A = 1024 + 32*24 + 17;  // 1809
  localparam int VPOS_B = 1024 + 32*16 + 17;  // 1553
  localparam int NENT   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic sd_a = 1'b0, sd_b = 1'b0, fill = 1'b0;
  logic mclk_a, sclk_a, lrck_a, valid_a;
  logic mclk_b, sclk_b, lrck_b, valid_b;
  logic [23:0] left_a, right_a;
  logic [15:0] left_b, right_b;

  int n_tests = 0;
  int n_fail  = 0;
  int tcnt;
  logic [31:0] pend_la = 0, pend_ra = 0, pend_lb = 0, pend_rb = 0;
  logic [31:0] cur_la = 0, cur_ra = 0, cur_lb = 0, cur_rb = 0;

  int pa[$], pb[$];
  logic [31:0] gla[$], gra[$], glb[$], grb[$], ela[$], era[$], elb[$], erb[$];

  always #5 clk = ~clk;

  i2s2_adc_rx #(.DATA_W(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .adc_sdout(sd_a),
    .mclk_o(mclk_a), .sclk_o(sclk_a), .lrck_o(lrck_a),
    .left_o(left_a), .right_o(right_a), .valid_o(valid_a));

  i2s2_adc_rx #(.DATA_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .adc_sdout(sd_b),
    .mclk_o(mclk_b), .sclk_o(sclk_b), .lrck_o(lrck_b),
    .left_o(left_b), .right_o(right_b), .valid_o(valid_b));

  // Reference frame position: cycles since enable/reset, modulo one frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tcnt <= 0;
    else if (!en) tcnt <= 0;
    else          tcnt <= (tcnt + 1) % 2048;
  end

  // ADC source: bit for slot s of a half frame is word[W-s] for s=1..W,
  // the filler level otherwise; new words only start at a frame boundary.
  function automatic logic bitval(input logic [31:0] w, input int width,
                                  input int c, input logic f);
    int slot;
    slot = (c % 1024) / 32;
    if (slot >= 1 && slot <= width) return w[width - slot];
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    #1;
    if (tcnt == 0) begin
      cur_la = pend_la; cur_ra = pend_ra; cur_lb = pend_lb; cur_rb = pend_rb;
    end
    sd_a = bitval((tcnt >= 1024) ? cur_ra : cur_la, 24, tcnt, fill);
    sd_b = bitval((tcnt >= 1024) ? cur_rb : cur_lb, 16, tcnt, fill);
  end

  // Records DUT pulses and the words the model says each pulse must carry.
  task automatic observe(input int n);
    repeat (n) begin
      @(negedge clk);
      if (valid_a) begin pa.push_back(tcnt); gla.push_back(32'(left_a)); gra.push_back(32'(right_a)); end
      if (valid_b) begin pb.push_back(tcnt); glb.push_back(32'(left_b)); grb.push_back(32'(right_b)); end
      if (tcnt == VPOS_A) begin ela.push_back(cur_la); era.push_back(cur_ra); end
      if (tcnt == VPOS_B) begin elb.push_back(cur_lb); erb.push_back(cur_rb); end
    end
  endtask

  task automatic test_reset;
    int bad = 0;
    en = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mclk_a, sclk_a, lrck_a, valid_a, left_a, right_a} !== '0)
      begin n_fail++; $display("FAIL reset_a: got %h/%h v=%b expected 0", left_a, right_a, valid_a); end
    n_tests++;
    if ({mclk_b, sclk_b, lrck_b, valid_b, left_b, right_b} !== '0)
      begin n_fail++; $display("FAIL reset_b: got %h/%h v=%b expected 0", left_b, right_b, valid_b); end
    rst_n = 1'b1;
    repeat (5000) begin
      @(negedge clk);
      if ({mclk_a, sclk_a, lrck_a, valid_a, left_a, right_a,
           mclk_b, sclk_b, lrck_b, valid_b, left_b, right_b} !== '0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL idle: %0d nonzero cycles, expected 0", bad); end
  endtask

  task automatic test_clocks;
    int bad = 0, rises = 0, levels = 0, edge_bad = 0;
    logic ps = 1'b0, pl = 1'b0;
    en = 1'b1;
    repeat (4096) begin
      @(negedge clk);
      if (mclk_a !== 1'((tcnt / 2) % 2) || sclk_a !== 1'((tcnt / 16) % 2) ||
          lrck_a !== 1'(tcnt / 1024) || mclk_b !== mclk_a || sclk_b !== sclk_a ||
          lrck_b !== lrck_a) bad++;
      if (!ps && sclk_a) rises++;
      if (lrck_a != pl) begin
        levels++;
        if (rises != 32) edge_bad++;
        rises = 0;
        if (!(ps && !sclk_a)) edge_bad++;
      end
      ps = sclk_a; pl = lrck_a;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL clk_div: %0d wrong cycles, expected 0", bad); end
    n_tests++;
    if (levels != 4) begin n_fail++; $display("FAIL lrck_levels: got %0d expected 4", levels); end
    n_tests++;
    if (edge_bad != 0) begin n_fail++; $display("FAIL sclk_per_lrck: %0d bad levels, expected 0", edge_bad); end
    en = 1'b0;
  endtask

  // Table of frames: fixed patterns, a framing pattern with ones only in the
  // ignored slots, random words, and MSB+LSB markers with ones in filler.
  task automatic test_capture;
    logic [31:0] tl[NENT], tr[NENT], tlb[NENT], trb[NENT];
    logic tf[NENT];
    int nmin;
    tl[0] = 32'hA5C3F1; tr[0] = 32'h5A3C0E; tlb[0] = 32'h8001; trb[0] = 32'h7FFE; tf[0] = 1'b0;
    tl[1] = 32'hA5C3F1; tr[1] = 32'h5A3C0E; tlb[1] = 32'h8001; trb[1] = 32'h7FFE; tf[1] = 1'b0;
    tl[2] = 32'h0;      tr[2] = 32'h0;      tlb[2] = 32'h0;    trb[2] = 32'h0;    tf[2] = 1'b1;
    for (int i = 3; i < NENT - 1; i++) begin
      tl[i] = $urandom & 32'hFFFFFF; tr[i] = $urandom & 32'hFFFFFF;
      tlb[i] = $urandom & 32'hFFFF;  trb[i] = $urandom & 32'hFFFF;
      tf[i] = 1'($urandom_range(0, 1));
    end
    tl[NENT-1] = 32'h800001; tr[NENT-1] = 32'h800001;
    tlb[NENT-1] = 32'h8001;  trb[NENT-1] = 32'h8001; tf[NENT-1] = 1'b1;
    pa.delete(); pb.delete(); gla.delete(); gra.delete(); glb.delete(); grb.delete();
    ela.delete(); era.delete(); elb.delete(); erb.delete();
    pend_la = tl[0]; pend_ra = tr[0]; pend_lb = tlb[0]; pend_rb = trb[0]; fill = tf[0];
    repeat (4) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < NENT; i++) begin
      observe(1900);
      if (i + 1 < NENT) begin
        pend_la = tl[i+1]; pend_ra = tr[i+1]; pend_lb = tlb[i+1]; pend_rb = trb[i+1];
      end
      observe(148);
      if (i + 1 < NENT) fill = tf[i+1];
    end
    n_tests++;
    if (pa.size() != NENT || pb.size() != NENT || ela.size() != NENT || elb.size() != NENT) begin
      n_fail++;
      $display("FAIL pulse_count: got a=%0d b=%0d expected %0d", pa.size(), pb.size(), NENT);
    end
    nmin = (pa.size() < ela.size()) ? pa.size() : ela.size();
    for (int i = 0; i < nmin; i++) begin
      n_tests++;
      if (pa[i] != VPOS_A || gla[i] !== ela[i] || gra[i] !== era[i]) begin
        n_fail++;
        $display("FAIL capture24[%0d]: got cnt=%0d %h/%h expected cnt=%0d %h/%h",
                 i, pa[i], gla[i], gra[i], VPOS_A, ela[i], era[i]);
      end
    end
    nmin = (pb.size() < elb.size()) ? pb.size() : elb.size();
    for (int i = 0; i < nmin; i++) begin
      n_tests++;
      if (pb[i] != VPOS_B || glb[i] !== elb[i] || grb[i] !== erb[i]) begin
        n_fail++;
        $display("FAIL capture16[%0d]: got cnt=%0d %h/%h expected cnt=%0d %h/%h",
                 i, pb[i], glb[i], grb[i], VPOS_B, elb[i], erb[i]);
      end
    end
  endtask

  task automatic test_disrupt;
    int k, bad;
    logic [31:0] hla, hra, hlb, hrb;
    // Reset at cnt=1500: everything clears without a clock edge.
    k = 0;
    while (tcnt != 1500 && k < 4096) begin @(negedge clk); k++; end
    n_tests++;
    if (tcnt != 1500) begin n_fail++; $display("FAIL wait_1500: timed out at cnt %0d", tcnt); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({mclk_a, sclk_a, lrck_a, valid_a, left_a, right_a, left_b, right_b} !== '0)
      begin n_fail++; $display("FAIL async_reset: got %h/%h %h/%h expected 0", left_a, right_a, left_b, right_b); end
    pend_la = $urandom & 32'hFFFFFF; pend_ra = $urandom & 32'hFFFFFF;
    pend_lb = $urandom & 32'hFFFF;   pend_rb = $urandom & 32'hFFFF; fill = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!valid_a && k < 2100);
    n_tests++;
    if (k != 1809 || 32'(left_a) !== pend_la || 32'(right_a) !== pend_ra ||
        32'(left_b) !== pend_lb || 32'(right_b) !== pend_rb) begin
      n_fail++;
      $display("FAIL after_reset: got k=%0d %h/%h %h/%h expected k=1809 %h/%h %h/%h",
               k, left_a, right_a, left_b, right_b, pend_la, pend_ra, pend_lb, pend_rb);
    end
    // en low at cnt=500: outputs hold, nothing else moves.
    hla = pend_la; hra = pend_ra; hlb = pend_lb; hrb = pend_rb;
    k = 0;
    while (tcnt != 500 && k < 4096) begin @(negedge clk); k++; end
    n_tests++;
    if (tcnt != 500) begin n_fail++; $display("FAIL wait_500: timed out at cnt %0d", tcnt); end
    en = 1'b0;
    pend_la = $urandom & 32'hFFFFFF; pend_ra = $urandom & 32'hFFFFFF;
    pend_lb = $urandom & 32'hFFFF;   pend_rb = $urandom & 32'hFFFF;
    bad = 0;
    repeat (3000) begin
      @(negedge clk);
      if (valid_a || valid_b || mclk_a || sclk_a || lrck_a || 32'(left_a) !== hla ||
          32'(right_a) !== hra || 32'(left_b) !== hlb || 32'(right_b) !== hrb) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL en_hold: %0d bad cycles, expected 0", bad); end
    en = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!valid_a && k < 2100);
    n_tests++;
    if (k != 1809 || 32'(left_a) !== pend_la || 32'(right_a) !== pend_ra ||
        32'(left_b) !== pend_lb || 32'(right_b) !== pend_rb) begin
      n_fail++;
      $display("FAIL after_en: got k=%0d %h/%h %h/%h expected k=1809 %h/%h %h/%h",
               k, left_a, right_a, left_b, right_b, pend_la, pend_ra, pend_lb, pend_rb);
    end
  endtask

  initial begin
    test_reset();
    test_clocks();
    test_capture();
    test_disrupt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/i2s2_adc_rx.md
# i2s2_adc_rx

I2S line-in receiver for the PmodI2S2 ADC (CS5343, slave mode) in the MIDI synth design. Runs on the 98.304 MHz audio system clock from the clock generator. Divides it down to MCLK/SCLK/LRCK for a 48 kHz, 64-SCLK-per-frame I2S stream. Deserializes SDOUT into parallel left/right samples, delivered with a one-cycle valid strobe.

## Interface

Parameters:
- DATA_W, 24: sample width in bits captured per channel; legal range 8..31.

Ports:
- clk  in  1  audio system clock, 98.304 MHz.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- en  in  1  run enable; low holds the block idle, counters and shift logic at 0.
- adc_sdout  in  1  serial data from the ADC, driven relative to sclk_o.
- mclk_o  out  1  ADC master clock, clk/4 = 24.576 MHz.
- sclk_o  out  1  serial bit clock, clk/32 = 3.072 MHz.
- lrck_o  out  1  word select, clk/2048 = 48 kHz; 0 = left, 1 = right.
- left_o  out  DATA_W  last complete left sample, MSB-aligned two's complement.
- right_o  out  DATA_W  last complete right sample, same frame as left_o.
- valid_o  out  1  one-cycle strobe: left_o/right_o updated this cycle.

## Operation

- 11-bit free-running frame counter cnt, increments by 1 per clk while en=1, wraps 2047 -> 0.
- en=0 (synchronous): cnt cleared to 0, shift register cleared, valid_o forced 0. left_o/right_o hold their last values.
- Clock outputs are flop-driven (no combinational decode): mclk_o = cnt[1], sclk_o = cnt[4], lrck_o = cnt[10].
- Slot decode: channel = cnt[10]; bit index b = cnt[9:5] (0..31 within the half frame); sample instant = cycle where cnt[4:0] = 16, i.e. the first clk cycle with sclk_o high.
- adc_sdout is registered once on every clk. The shift register takes the registered value at each sample instant.
- I2S framing: b = 0 is the one-bit delay slot and is ignored. b = 1..DATA_W are data bits, MSB first. b > DATA_W are ignored.
- At the sample instant with b = DATA_W:
  - channel 0: the completed word moves to an internal left hold register.
  - channel 1: left_o <= left hold, right_o <= completed word, and valid_o pulses on the following cycle.
- The shift register is cleared at the sample instant with b = 0 of each channel. A channel word never contains bits of the previous channel.
- A right word without a preceding complete left word does not produce valid_o. A left slot interrupted by en=0 or reset discards the frame.
- No backpressure. The consumer must take samples within 2048 cycles. No overrun flag exists.

## Timing

- Reset values: cnt=0, mclk_o=0, sclk_o=0, lrck_o=0, left_o=0, right_o=0, valid_o=0, shift and hold registers 0.
- Cycle 0 is the first rising clk edge with rst_n=1 and en=1, where cnt = 0.
- mclk_o: 2 cycles high / 2 low. sclk_o: 16/16. lrck_o: 1024/1024.
- lrck_o changes on the same clk edge as an sclk_o falling edge.
- Sampling adc_sdout 16 clk cycles after the ADC's launch edge (sclk falling) leaves ample setup/hold margin.
- valid_o is high exactly when cnt = 1024 + 32*DATA_W + 17. For DATA_W=24 that is cnt = 1809.
  - First pulse occurs in cycle 1809 after enable/reset release.
  - Subsequent pulses every 2048 cycles.
- Latency from the right-channel LSB sample instant to valid_o: 1 cycle. left_o/right_o change only in the valid_o cycle.
- rst_n asserted mid-frame: all state returns to reset values immediately, without waiting for a clock edge. The partial frame is lost.
- en deasserted mid-frame: same behaviour on the next clk edge, except left_o/right_o hold.

## Test plan

- Reset/idle: hold rst_n=0, then release with en=0 for 5000 cycles -> all outputs remain 0; no valid_o.
- Clock generation: en=1 -> mclk_o period 4, sclk_o period 32, lrck_o period 2048 cycles. Exactly 32 sclk_o rising edges per lrck_o level. lrck_o changes together with sclk_o falling.
- Capture, DATA_W=24: model drives left 0x A5C3F1, right 0x 5A3C0E per I2S on sclk_o falling -> valid_o at cycle 1809 with left_o=0xA5C3F1, right_o=0x5A3C0E. Repeats every 2048 cycles. Changing the pattern takes effect on the next frame only.
- Framing edges: drive 1 in the delay slot and in bits b>24, 0 elsewhere -> captured samples are 0x000000. Drive 0x800001 -> MSB and LSB both land correctly.
- Mid-frame disruption: pull rst_n low at cnt=1500, release -> outputs 0 at once; first valid_o 1809 cycles after release. en=0 at cnt=500 -> left_o/right_o keep prior values; no spurious valid_o.
- Parameter: DATA_W=16, left 0x8001, right 0x7FFE -> valid_o when cnt=1553 with exact values. Bits b=17..31 ignored.
